// File: rtl/execute_muldiv.sv
// Execute stage: registered single-cycle ALU plus iterative mul/div owning HI/LO.
// Latency: ALU ops 1 cycle; mul/div busy DATA_W+1 cycles after accept, HI/LO written on FIX exit.
// Backpressure: in_ready low while mul/div in flight; stall_req tells decode to hold its op.
module execute_muldiv #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [REG_ADDR_W-1:0] dest_addr,
    input  logic                  wr_en,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] out_dest_addr,
    output logic                  out_wr_en,
    output logic [DATA_W-1:0]     out_wdata,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  stall_req
);
    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [4:0] OP_AND  = 5'd0,  OP_OR    = 5'd1,  OP_XOR  = 5'd2,  OP_NOR  = 5'd3;
    localparam logic [4:0] OP_LUI  = 5'd4,  OP_SLL   = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
    localparam logic [4:0] OP_MOVZ = 5'd8,  OP_MOVN  = 5'd9,  OP_MFHI = 5'd10, OP_MFLO = 5'd11;
    localparam logic [4:0] OP_MTHI = 5'd12, OP_MTLO  = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_DIVU  = 5'd17;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t              state;
    logic [SHAMT_W-1:0]  cnt;
    logic                is_div;
    logic                neg_res;
    logic                neg_rem;
    logic                div_zero;
    logic [DATA_W-1:0]   a_raw;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   opnd;

    logic                accept;
    logic [DATA_W-1:0]   res;
    logic                res_wr;
    logic [SHAMT_W-1:0]  sh;
    logic                is_md;
    logic                is_signed_op;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    assign in_ready  = (state == IDLE);
    assign stall_req = in_valid & ~in_ready;
    assign accept    = in_valid & in_ready;

    assign sh           = a[SHAMT_W-1:0];
    assign is_md        = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg        = is_signed_op & a[DATA_W-1];
    assign b_neg        = is_signed_op & b[DATA_W-1];
    assign a_mag        = a_neg ? -a : a;
    assign b_mag        = b_neg ? -b : b;

    always_comb begin
        res    = '0;
        res_wr = 1'b0;
        case (op)
            OP_AND:  begin res = a & b;    res_wr = wr_en; end
            OP_OR:   begin res = a | b;    res_wr = wr_en; end
            OP_XOR:  begin res = a ^ b;    res_wr = wr_en; end
            OP_NOR:  begin res = ~(a | b); res_wr = wr_en; end
            OP_LUI:  begin res = b;        res_wr = wr_en; end
            OP_SLL:  begin res = b << sh;  res_wr = wr_en; end
            OP_SRL:  begin res = b >> sh;  res_wr = wr_en; end
            OP_SRA:  begin res = $signed(b) >>> sh; res_wr = wr_en; end
            OP_MOVZ: begin res = a; res_wr = wr_en & (b == '0); end
            OP_MOVN: begin res = a; res_wr = wr_en & (b != '0); end
            OP_MFHI: begin res = hi; res_wr = wr_en; end
            OP_MFLO: begin res = lo; res_wr = wr_en; end
            OP_MTHI: res = a;
            OP_MTLO: res = a;
            default: ;
        endcase
    end

    // One iteration step: multiply shifts {acc_hi,acc_lo} right after a conditional add;
    // divide shifts left one dividend bit into the remainder and keeps a non-negative trial.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_trial;
    logic                div_ok;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_trial[DATA_W];

    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

    assign prod_raw = {acc_hi, acc_lo};
    assign prod     = neg_res ? -prod_raw : prod_raw;

    always_comb begin
        fix_hi = prod[2*DATA_W-1:DATA_W];
        fix_lo = prod[DATA_W-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem ? -acc_hi : acc_hi;
                fix_lo = neg_res ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_div        <= 1'b0;
            neg_res       <= 1'b0;
            neg_rem       <= 1'b0;
            div_zero      <= 1'b0;
            a_raw         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            opnd          <= '0;
            out_valid     <= 1'b0;
            out_dest_addr <= '0;
            out_wr_en     <= 1'b0;
            out_wdata     <= '0;
            hi            <= '0;
            lo            <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_valid     <= 1'b1;
                        out_dest_addr <= dest_addr;
                        out_wr_en     <= res_wr;
                        out_wdata     <= res;
                        if (op == OP_MTHI) hi <= a;
                        if (op == OP_MTLO) lo <= a;
                        if (is_md) begin
                            state    <= CALC;
                            cnt      <= SHAMT_W'(DATA_W - 1);
                            is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= (b == '0);
                            a_raw    <= a;
                            acc_hi   <= '0;
                            acc_lo   <= a_mag;
                            opnd     <= b_mag;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ok ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[DATA_W:1];
                        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: transaction-level reference model with per-cycle compare,
// directed literal cases, then randomized op streams.
module tb_execute_muldiv;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [AW-1:0] dest_addr = '0;
    logic          wr_en = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_dest_addr;
    logic          out_wr_en;
    logic [W-1:0]  out_wdata;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          stall_req;

    always #5 clk = ~clk;

    execute_muldiv #(.DATA_W(W), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .dest_addr(dest_addr), .wr_en(wr_en), .out_valid(out_valid),
        .out_dest_addr(out_dest_addr), .out_wr_en(out_wr_en), .out_wdata(out_wdata),
        .hi(hi), .lo(lo), .stall_req(stall_req)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: architectural results from plain arithmetic, busy time as a countdown.
    int            m_busy = 0;
    logic [W-1:0]  m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic          m_ov = 1'b0, m_wr = 1'b0, m_chk_wdata = 1'b0;
    logic [AW-1:0] m_dest = '0;
    logic [W-1:0]  m_wdata = '0;

    task automatic model_accept();
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, pr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        m_ov = 1'b1; m_dest = dest_addr; m_wr = 1'b0; m_wdata = '0; m_chk_wdata = 1'b1;
        case (op)
            5'd0:  begin m_wdata = a & b;    m_wr = wr_en; end
            5'd1:  begin m_wdata = a | b;    m_wr = wr_en; end
            5'd2:  begin m_wdata = a ^ b;    m_wr = wr_en; end
            5'd3:  begin m_wdata = ~(a | b); m_wr = wr_en; end
            5'd4:  begin m_wdata = b;        m_wr = wr_en; end
            5'd5:  begin m_wdata = b << a[4:0]; m_wr = wr_en; end
            5'd6:  begin m_wdata = b >> a[4:0]; m_wr = wr_en; end
            5'd7:  begin m_wdata = 32'(sb >>> a[4:0]); m_wr = wr_en; end
            5'd8:  begin m_wdata = a; m_wr = wr_en && (b == 0); end
            5'd9:  begin m_wdata = a; m_wr = wr_en && (b != 0); end
            5'd10: begin m_wdata = m_hi; m_wr = wr_en; end
            5'd11: begin m_wdata = m_lo; m_wr = wr_en; end
            5'd12: begin m_hi = a; m_chk_wdata = 1'b0; end
            5'd13: begin m_lo = a; m_chk_wdata = 1'b0; end
            5'd14: begin pr = sa * sb; {p_hi, p_lo} = pr; m_busy = W + 1; end
            5'd15: begin pr = ua * ub; {p_hi, p_lo} = pr; m_busy = W + 1; end
            5'd16, 5'd17: begin
                if (b == 0) begin
                    p_lo = '1; p_hi = a;
                end else if (op == 5'd16) begin
                    q = sa / sb; r = sa % sb;
                    p_lo = q[31:0]; p_hi = r[31:0];
                end else begin
                    q = ua / ub; r = ua % ub;
                    p_lo = q[31:0]; p_hi = r[31:0];
                end
                m_busy = W + 1;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_hi = '0; m_lo = '0; m_ov = 1'b0;
        end else if (m_busy > 0) begin
            m_ov = 1'b0;
            m_busy--;
            if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (in_valid) begin
            model_accept();
        end else begin
            m_ov = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
        chk("stall_req", 32'(stall_req), 32'(in_valid && (m_busy != 0)));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (m_ov) begin
            chk("out_dest_addr", 32'(out_dest_addr), 32'(m_dest));
            chk("out_wr_en", 32'(out_wr_en), 32'(m_wr));
            if (m_chk_wdata) chk("out_wdata", out_wdata, m_wdata);
        end
    end

    int stall_cnt = 0;
    always @(posedge clk) if (stall_req === 1'b1) stall_cnt++;

    task automatic wait_ready();
        int k = 0;
        while (in_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=busy expected=idle at %0t", $time);
        end
    endtask

    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] d, input logic w);
        in_valid = 1'b1; op = o; a = x; b = y; dest_addr = d; wr_en = w;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_hi", hi, 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);

        send(5'd0, 32'hF0F0_0004, 32'h8000_00FF, 5'd1, 1'b1);
        chk("t1_and", out_wdata, 32'h8000_0004);
        send(5'd7, 32'hF0F0_0004, 32'h8000_00FF, 5'd2, 1'b1);
        chk("t1_sra", out_wdata, 32'hF800_000F);
        send(5'd3, 32'hF0F0_0004, 32'h8000_00FF, 5'd3, 1'b1);
        chk("t1_nor", out_wdata, 32'h0F0F_FF00);

        send(5'd8, 32'd5, 32'd0, 5'd4, 1'b1);
        chk("t2_movz_wr", 32'(out_wr_en), 32'h1);
        chk("t2_movz_data", out_wdata, 32'd5);
        send(5'd9, 32'd5, 32'd0, 5'd4, 1'b1);
        chk("t2_movn_wr", 32'(out_wr_en), 32'h0);

        send(5'd14, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
        stall_cnt = 0;
        send(5'd11, 32'd0, 32'd0, 5'd6, 1'b1);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd33);
        chk("t3_mflo", out_wdata, 32'hFFFF_FFEB);
        send(5'd10, 32'd0, 32'd0, 5'd7, 1'b1);
        chk("t3_mfhi", out_wdata, 32'hFFFF_FFFF);

        send(5'd16, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
        wait_ready();
        chk("t4_div_lo", lo, 32'hFFFF_FFFD);
        chk("t4_div_hi", hi, 32'hFFFF_FFFF);
        send(5'd17, 32'd7, 32'd0, 5'd0, 1'b0);
        wait_ready();
        chk("t4_divu0_lo", lo, 32'hFFFF_FFFF);
        chk("t4_divu0_hi", hi, 32'd7);
        send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
        wait_ready();
        chk("t4_minneg1_lo", lo, 32'h8000_0000);
        chk("t4_minneg1_hi", hi, 32'h0);

        send(5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        wait_ready();
        chk("t5_multu_hi", hi, 32'hFFFF_FFFE);
        chk("t5_multu_lo", lo, 32'h1);
        send(5'd12, 32'h1234, 32'd0, 5'd0, 1'b1);
        chk("t5_mthi", hi, 32'h1234);
        chk("t5_mthi_wr", 32'(out_wr_en), 32'h0);

        send(5'd16, 32'd100, 32'd7, 5'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready", 32'(in_ready), 32'h1);
        chk("t6_hi", hi, 32'h0);
        chk("t6_lo", lo, 32'h0);
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [4:0] o;
            o = 5'($urandom_range(0, 20));
            send(o, pick(), pick(), 5'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
